// File: rtl/vga_move_ctrl.sv
// Bouncing-block motion controller: updates position, speed and run state once per
// frame at the start of vertical blanking, reflecting the block off the border walls.
module vga_move_ctrl #(
    parameter logic [9:0] H_DISP    = 10'd640,
    parameter logic [9:0] V_DISP    = 10'd480,
    parameter logic [9:0] SIDE_W    = 10'd40,
    parameter logic [9:0] BLOCK_W   = 10'd40,
    parameter logic [2:0] SPEED_MAX = 3'd7,
    parameter logic [9:0] INIT_XY   = 10'd100
) (
    input  logic       vga_clk,
    input  logic       sys_rst_n,
    input  logic       frame_start,
    input  logic       key_pause,
    input  logic       key_speed_up,
    input  logic       key_speed_dn,
    output logic [9:0] block_x,
    output logic [9:0] block_y,
    output logic [2:0] speed,
    output logic [1:0] run_state,
    output logic       bounce_x,
    output logic       bounce_y
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    // Limits kept in signed 12-bit so that a step past either wall never wraps.
    localparam logic signed [11:0] XMIN_S = $signed({2'b00, SIDE_W});
    localparam logic signed [11:0] YMIN_S = $signed({2'b00, SIDE_W});
    localparam logic signed [11:0] XMAX_S = $signed({2'b00, H_DISP}) - $signed({2'b00, SIDE_W})
                                          - $signed({2'b00, BLOCK_W});
    localparam logic signed [11:0] YMAX_S = $signed({2'b00, V_DISP}) - $signed({2'b00, SIDE_W})
                                          - $signed({2'b00, BLOCK_W});

    // Axis index 0 is x, 1 is y.
    state_t          r_state;
    logic [1:0][9:0] r_pos;
    logic [1:0]      r_dir;
    logic [1:0]      r_bounce;
    logic [2:0]      r_speed;
    logic [2:0]      r_speed_pend;
    logic            r_toggle_pend;

    state_t          w_state_next;
    logic [1:0][9:0] w_pos_next;
    logic [1:0]      w_dir_next;
    logic [1:0]      w_bounce_next;
    logic [2:0]      w_speed_next;
    logic [2:0]      w_speed_pend_next;
    logic            w_toggle_pend_next;
    logic            w_move;

    assign w_move = frame_start && (r_state == ST_RUN);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            localparam logic signed [11:0] L_MIN = (gi == 0) ? XMIN_S : YMIN_S;
            localparam logic signed [11:0] L_MAX = (gi == 0) ? XMAX_S : YMAX_S;

            logic signed [11:0] w_step;
            logic [9:0]         w_pos;
            logic               w_dir;
            logic               w_bounce;

            always_comb begin
                w_step   = r_dir[gi] ? ($signed({2'b00, r_pos[gi]}) + $signed({9'b0, r_speed}))
                                     : ($signed({2'b00, r_pos[gi]}) - $signed({9'b0, r_speed}));
                w_pos    = r_pos[gi];
                w_dir    = r_dir[gi];
                w_bounce = 1'b0;
                if (w_move) begin
                    // Landing exactly on a wall counts as a hit and reflects.
                    if (w_step >= L_MAX) begin
                        w_pos    = L_MAX[9:0];
                        w_dir    = 1'b0;
                        w_bounce = 1'b1;
                    end else if (w_step <= L_MIN) begin
                        w_pos    = L_MIN[9:0];
                        w_dir    = 1'b1;
                        w_bounce = 1'b1;
                    end else begin
                        w_pos    = w_step[9:0];
                    end
                end
            end

            assign w_pos_next[gi]    = w_pos;
            assign w_dir_next[gi]    = w_dir;
            assign w_bounce_next[gi] = w_bounce;
        end
    endgenerate

    always_comb begin
        w_state_next       = r_state;
        w_toggle_pend_next = r_toggle_pend;
        w_speed_pend_next  = r_speed_pend;
        w_speed_next       = r_speed;

        case (r_state)
            ST_IDLE:  if (frame_start)                  w_state_next = ST_RUN;
            ST_RUN:   if (frame_start && r_toggle_pend) w_state_next = ST_PAUSE;
            ST_PAUSE: if (frame_start && r_toggle_pend) w_state_next = ST_RUN;
            default:                                    w_state_next = ST_IDLE;
        endcase

        // A pause key landing on frame_start is held over for the next frame.
        if (frame_start) begin
            w_toggle_pend_next = key_pause;
        end else if (key_pause) begin
            w_toggle_pend_next = ~r_toggle_pend;
        end

        if (key_speed_up && !key_speed_dn && (r_speed_pend < SPEED_MAX)) begin
            w_speed_pend_next = r_speed_pend + 3'd1;
        end else if (key_speed_dn && !key_speed_up && (r_speed_pend > 3'd1)) begin
            w_speed_pend_next = r_speed_pend - 3'd1;
        end

        if (frame_start) begin
            w_speed_next = r_speed_pend;
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state       <= ST_IDLE;
            r_pos         <= {INIT_XY, INIT_XY};
            r_dir         <= 2'b11;
            r_bounce      <= 2'b00;
            r_speed       <= 3'd1;
            r_speed_pend  <= 3'd1;
            r_toggle_pend <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_pos         <= w_pos_next;
            r_dir         <= w_dir_next;
            r_bounce      <= w_bounce_next;
            r_speed       <= w_speed_next;
            r_speed_pend  <= w_speed_pend_next;
            r_toggle_pend <= w_toggle_pend_next;
        end
    end

    assign block_x   = r_pos[0];
    assign block_y   = r_pos[1];
    assign speed     = r_speed;
    assign run_state = r_state;
    assign bounce_x  = r_bounce[0];
    assign bounce_y  = r_bounce[1];

endmodule

// File: tb/tb_vga_move_ctrl.sv
// Directed bench for vga_move_ctrl: start-up, speed keys, wall bounce, pause and
// mid-operation reset, each step against hand-computed values.
module tb_vga_move_ctrl;

    logic       vga_clk;
    logic       sys_rst_n;
    logic       frame_start;
    logic       key_pause;
    logic       key_speed_up;
    logic       key_speed_dn;
    logic [9:0] block_x;
    logic [9:0] block_y;
    logic [2:0] speed;
    logic [1:0] run_state;
    logic       bounce_x;
    logic       bounce_y;

    int n_cmp;
    int n_err;
    int bx_after;
    int by_after;
    int bx_later;
    int by_later;
    int px;
    int py;

    vga_move_ctrl dut (
        .vga_clk      (vga_clk),
        .sys_rst_n    (sys_rst_n),
        .frame_start  (frame_start),
        .key_pause    (key_pause),
        .key_speed_up (key_speed_up),
        .key_speed_dn (key_speed_dn),
        .block_x      (block_x),
        .block_y      (block_y),
        .speed        (speed),
        .run_state    (run_state),
        .bounce_x     (bounce_x),
        .bounce_y     (bounce_y)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // One frame_start cycle; bounce flags are captured right after it and one cycle later.
    task automatic frame(input logic up = 1'b0, input logic dn = 1'b0);
        @(negedge vga_clk);
        frame_start  = 1'b1;
        key_speed_up = up;
        key_speed_dn = dn;
        @(negedge vga_clk);
        frame_start  = 1'b0;
        key_speed_up = 1'b0;
        key_speed_dn = 1'b0;
        bx_after = bounce_x;
        by_after = bounce_y;
        @(negedge vga_clk);
        bx_later = bounce_x;
        by_later = bounce_y;
    endtask

    task automatic keys(input logic up, input logic dn, input logic pz);
        @(negedge vga_clk);
        key_speed_up = up;
        key_speed_dn = dn;
        key_pause    = pz;
        @(negedge vga_clk);
        key_speed_up = 1'b0;
        key_speed_dn = 1'b0;
        key_pause    = 1'b0;
    endtask

    task automatic chk_pos(input string tag, input int ex, input int ey);
        chk({tag, "_x"}, int'(block_x), ex);
        chk({tag, "_y"}, int'(block_y), ey);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        sys_rst_n    = 1'b0;
        frame_start  = 1'b0;
        key_pause    = 1'b0;
        key_speed_up = 1'b0;
        key_speed_dn = 1'b0;
        repeat (3) @(negedge vga_clk);
        chk_pos("rst_pos", 100, 100);
        chk("rst_state", int'(run_state), 0);
        chk("rst_speed", int'(speed), 1);
        chk("rst_bounce", int'({bounce_x, bounce_y}), 0);
        sys_rst_n = 1'b1;
        repeat (4) @(negedge vga_clk);
        chk("idle_hold", int'(run_state), 0);

        // Start-up: first frame only enters RUN, second moves by 1.
        frame();
        chk("f1_state", int'(run_state), 1);
        chk_pos("f1_pos", 100, 100);
        frame();
        chk_pos("f2_pos", 101, 101);

        // Three speed-up keys: applied speed changes at the next frame, motion lags a frame.
        repeat (3) keys(1'b1, 1'b0, 1'b0);
        chk("spd_not_yet", int'(speed), 1);
        frame();
        chk("spd4", int'(speed), 4);
        chk_pos("f3_pos", 102, 102);
        frame();
        chk_pos("f4_pos", 106, 106);

        // Run toward the right wall; y hits the bottom wall on the way.
        for (int k = 1; k <= 113; k++) begin
            frame();
            if (k == 74) begin
                chk_pos("ybounce_pos", 402, 400);
                chk("ybounce_pulse", by_after, 1);
                chk("ybounce_one", by_later, 0);
            end
        end
        chk_pos("near_wall", 558, 244);
        frame();
        chk_pos("xwall", 560, 240);
        chk("xbounce_pulse", bx_after, 1);
        chk("xbounce_one", bx_later, 0);
        chk("xbounce_no_y", by_after, 0);
        frame();
        chk_pos("xreflect", 556, 236);

        // Pause: the frame that takes the toggle is still a RUN frame.
        keys(1'b0, 1'b0, 1'b1);
        frame();
        chk("pause_state", int'(run_state), 2);
        chk_pos("pause_pos", 552, 232);
        for (int k = 0; k < 3; k++) begin
            frame();
            chk("paused_state", int'(run_state), 2);
            chk_pos("frozen", 552, 232);
        end
        keys(1'b0, 1'b0, 1'b1);
        frame();
        chk("resume_state", int'(run_state), 1);
        chk_pos("resume_pos", 552, 232);
        frame();
        chk_pos("resume_move", 548, 228);
        chk("resume_speed", int'(speed), 4);

        // Speed saturation and simultaneous keys.
        repeat (10) keys(1'b0, 1'b1, 1'b0);
        frame();
        chk("spd_min", int'(speed), 1);
        keys(1'b1, 1'b1, 1'b0);
        frame();
        chk("spd_both", int'(speed), 1);
        repeat (10) keys(1'b0, 1'b1, 1'b0);
        frame();
        chk("spd_min2", int'(speed), 1);
        repeat (10) keys(1'b1, 1'b0, 1'b0);
        frame();
        chk("spd_max", int'(speed), 7);
        // A key on the frame_start cycle belongs to the next frame.
        frame(1'b0, 1'b1);
        chk("spd_coincide", int'(speed), 7);
        frame();
        chk("spd_deferred", int'(speed), 6);

        // Reset while paused with a toggle pending.
        keys(1'b0, 1'b0, 1'b1);
        frame();
        chk("pre_rst_pause", int'(run_state), 2);
        keys(1'b0, 1'b0, 1'b1);
        px = int'(block_x);
        py = int'(block_y);
        chk("pre_rst_frozen", int'(block_x) + int'(block_y), px + py);
        @(negedge vga_clk);
        sys_rst_n = 1'b0;
        #1;
        chk_pos("async_rst_pos", 100, 100);
        chk("async_rst_state", int'(run_state), 0);
        chk("async_rst_speed", int'(speed), 1);
        @(negedge vga_clk);
        sys_rst_n = 1'b1;
        frame();
        chk("post_rst_f1", int'(run_state), 1);
        chk_pos("post_rst_f1_pos", 100, 100);
        frame();
        chk("post_rst_f2", int'(run_state), 1);
        chk_pos("post_rst_f2_pos", 101, 101);
        chk("post_rst_speed", int'(speed), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
